// File: rtl/sha_pkg.sv
// Types and sizes shared by the byte-stream blocks around the hash core.
// The serializer state enum is common to the transmit serializer and the message buffer.
package sha_pkg;
    localparam int DIGEST_BYTES = 32;
    localparam int BLOCK_W      = 256;
    localparam int BYTE_W       = 8;
    localparam int SER_CNT_W    = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;
endpackage

// File: rtl/digest_serializer_256b_if.sv
// Block-in / byte-out handshake bundle for digest_serializer_256b.
// The slave modport is the serializer's view; master is the producer/consumer side.
interface digest_serializer_256b_if
    import sha_pkg::*;
#(
    parameter int N_BYTES = DIGEST_BYTES
);
    logic                   blk_valid;
    logic                   blk_ready;
    logic [8*N_BYTES-1:0]   blk_data;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [BYTE_W-1:0]      out_data;
    logic                   out_last;
    logic                   busy;

    modport master (
        output blk_valid, blk_data, flush, out_ready,
        input  blk_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  blk_valid, blk_data, flush, out_ready,
        output blk_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/digest_hold_buf.sv
// Single-entry block hold register with valid flag (load / take / clear).
// Only compiled when DIGEST_SER_DOUBLE_BUF_EN is defined.
`ifdef DIGEST_SER_DOUBLE_BUF_EN
module digest_hold_buf #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_take,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic [W-1:0] o_data
);
    logic         r_full;
    logic [W-1:0] r_data;

    // Clear wins so a flush can never leave a stale block behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
endmodule
`endif

// File: rtl/digest_serializer_256b.sv
// Drains a 256-bit block as 32 big-endian bytes on a valid/ready byte stream.
// Define DIGEST_SER_DOUBLE_BUF_EN to add a hold register for zero-bubble back-to-back blocks.
//
//   state | meaning
//   IDLE  | no block in the shift register, out_valid low
//   SEND  | presenting shreg's top byte, cnt = index of that byte
module digest_serializer_256b
    import sha_pkg::*;
#(
    parameter int N_BYTES = DIGEST_BYTES,
    parameter int CNT_W   = SER_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    digest_serializer_256b_if.slave   bus
);
    localparam int BLK_W = 8 * N_BYTES;

    ser_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [BLK_W-1:0]   r_shreg, w_shreg_nxt;

    logic w_blk_hs;
    logic w_byte_hs;
    logic w_last;
    logic w_out_valid;
    logic w_blk_ready;

`ifdef DIGEST_SER_DOUBLE_BUF_EN
    logic               w_hold_full;
    logic               w_hold_load;
    logic               w_hold_take;
    logic               w_hold_clear;
    logic [BLK_W-1:0]   w_hold_data;

    digest_hold_buf #(
        .W (BLK_W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_hold_load),
        .i_take  (w_hold_take),
        .i_clear (w_hold_clear),
        .i_data  (bus.blk_data),
        .o_full  (w_hold_full),
        .o_data  (w_hold_data)
    );

    assign w_blk_ready = !w_hold_full && !rst && !bus.flush;
    assign bus.busy    = (r_state == SEND) || w_hold_full;
`else
    assign w_blk_ready = (r_state == IDLE) && !rst && !bus.flush;
    assign bus.busy    = (r_state == SEND);
`endif

    assign w_out_valid = (r_state == SEND);
    assign w_blk_hs    = bus.blk_valid && w_blk_ready;
    assign w_byte_hs   = w_out_valid && bus.out_ready;
    assign w_last      = (r_cnt == CNT_W'(N_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
`ifdef DIGEST_SER_DOUBLE_BUF_EN
        w_hold_load  = 1'b0;
        w_hold_take  = 1'b0;
        w_hold_clear = 1'b0;
`endif
        if (bus.flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_shreg_nxt = '0;
`ifdef DIGEST_SER_DOUBLE_BUF_EN
            w_hold_clear = 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_blk_hs) begin
                        w_state_nxt = SEND;
                        w_cnt_nxt   = '0;
                        w_shreg_nxt = bus.blk_data;
                    end
                end
                SEND: begin
                    if (w_byte_hs && w_last) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        w_shreg_nxt = '0;
`ifdef DIGEST_SER_DOUBLE_BUF_EN
                        // Next block goes straight into shreg so byte 0 follows with no gap.
                        if (w_hold_full) begin
                            w_state_nxt = SEND;
                            w_shreg_nxt = w_hold_data;
                            w_hold_take = 1'b1;
                        end else if (w_blk_hs) begin
                            w_state_nxt = SEND;
                            w_shreg_nxt = bus.blk_data;
                        end
`endif
                    end else begin
                        if (w_byte_hs) begin
                            w_cnt_nxt   = r_cnt + CNT_W'(1);
                            w_shreg_nxt = {r_shreg[BLK_W-BYTE_W-1:0], BYTE_W'(0)};
                        end
`ifdef DIGEST_SER_DOUBLE_BUF_EN
                        if (w_blk_hs) begin
                            w_hold_load = 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = '0;
                end
            endcase
        end
    end

    assign bus.blk_ready = w_blk_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_shreg[BLK_W-1 -: BYTE_W];
    assign bus.out_last  = w_out_valid && w_last;
endmodule

// File: tb/tb_digest_serializer_256b.sv
// Directed bench for digest_serializer_256b: table of whole-block drains plus
// hand-written back-to-back, flush, mid-block reset and hold-discard sequences.
module tb_digest_serializer_256b;
    import sha_pkg::*;

`ifdef DIGEST_SER_DOUBLE_BUF_EN
    localparam logic [63:0] RDY_IN_SEND = 64'd1;
    localparam int          EXP_GAP     = 1;
`else
    localparam logic [63:0] RDY_IN_SEND = 64'd0;
    localparam int          EXP_GAP     = 2;
`endif

    localparam logic [255:0] BLK_INC =
        256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    localparam logic [255:0] BLK_AA  = {32{8'hAA}};
    localparam logic [255:0] BLK_55  = {32{8'h55}};
    localparam logic [255:0] BLK_MIX =
        256'h0123456789ABCDEFFEDCBA9876543210DEADBEEFCAFEF00D5A5AA5A5C3C33C3C;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    digest_serializer_256b_if bus ();

    digest_serializer_256b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] blk;
        bit           stall;
        logic [7:0]   exp_first;
        logic [7:0]   exp_last;
        int           exp_cycles;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers blk once, then consumes up to n_bytes bytes; returns bytes 0/last-seen and cycles used.
    task automatic send_block(input logic [255:0] blk, input bit stall, input string nm,
                              input int n_bytes, output logic [7:0] first_b,
                              output logic [7:0] last_b, output int cycles);
        int  k;
        int  cyc;
        int  wt;
        logic [255:0] model;
        bit  rdy;
        first_b = 8'h00;
        last_b  = 8'h00;
        model   = blk;
        wt      = 0;
        bus.blk_data  = blk;
        bus.blk_valid = 1'b1;
        while (!bus.blk_ready && wt < 10) begin
            tick();
            wt++;
        end
        chk({nm, "_accept"}, 64'(bus.blk_ready), 64'd1);
        tick();
        bus.blk_valid = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < n_bytes && cyc < 300) begin
            chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
            chk({nm, "_data"}, 64'(bus.out_data), 64'(model[255 - 8*k -: 8]));
            chk({nm, "_last"}, 64'(bus.out_last), 64'(k == 31));
            chk({nm, "_blk_ready"}, 64'(bus.blk_ready), RDY_IN_SEND);
            if (k == 0)  first_b = bus.out_data;
            if (k == 31) last_b  = bus.out_data;
            rdy = stall ? (cyc % 2 == 0) : 1'b1;
            bus.out_ready = rdy;
            tick();
            if (rdy) k++;
            cyc++;
        end
        chk({nm, "_bytes"}, 64'(k), 64'(n_bytes));
        cycles = cyc;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        vec_t        vecs[5];
        logic [7:0]  fb;
        logic [7:0]  lb;
        int          cyc;
        int          nbytes;
        int          accepted;
        int          a_last;
        int          b_first;

        n_vec = 0;
        n_err = 0;

        vecs[0] = '{BLK_INC, 1'b0, 8'h00, 8'h1F, 32};
        vecs[1] = '{BLK_INC, 1'b1, 8'h00, 8'h1F, 63};
        vecs[2] = '{BLK_AA,  1'b0, 8'hAA, 8'hAA, 32};
        vecs[3] = '{BLK_55,  1'b1, 8'h55, 8'h55, 63};
        vecs[4] = '{BLK_MIX, 1'b0, 8'h01, 8'h3C, 32};

        rst           = 1'b1;
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_blk_ready", 64'(bus.blk_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_blk_ready", 64'(bus.blk_ready), 64'd1);

        // Table: whole blocks, free-running and stalled sinks.
        for (int i = 0; i < 5; i++) begin
            send_block(vecs[i].blk, vecs[i].stall, $sformatf("vec%0d", i), 32, fb, lb, cyc);
            chk($sformatf("vec%0d_first", i),  64'(fb),  64'(vecs[i].exp_first));
            chk($sformatf("vec%0d_lastb", i),  64'(lb),  64'(vecs[i].exp_last));
            chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cycles));
            chk($sformatf("vec%0d_end_valid", i), 64'(bus.out_valid), 64'd0);
            chk($sformatf("vec%0d_end_busy", i),  64'(bus.busy),      64'd0);
            chk($sformatf("vec%0d_end_ready", i), 64'(bus.blk_ready), 64'd1);
        end

        // Back-to-back A then B with blk_valid held high.
        bus.blk_data  = BLK_AA;
        bus.blk_valid = 1'b1;
        bus.out_ready = 1'b1;
        nbytes   = 0;
        accepted = 0;
        a_last   = -1;
        b_first  = -1;
        cyc      = 0;
        while (nbytes < 64 && cyc < 200) begin
            if (bus.blk_valid && bus.blk_ready) accepted++;
            if (bus.out_valid) begin
                chk("b2b_data", 64'(bus.out_data), (nbytes < 32) ? 64'hAA : 64'h55);
                chk("b2b_last", 64'(bus.out_last), 64'(nbytes % 32 == 31));
                if (nbytes == 31) a_last  = cyc;
                if (nbytes == 32) b_first = cyc;
                nbytes++;
            end
            tick();
            if (accepted == 1) bus.blk_data  = BLK_55;
            if (accepted >= 2) bus.blk_valid = 1'b0;
            cyc++;
        end
        chk("b2b_bytes", 64'(nbytes), 64'd64);
        chk("b2b_gap",   64'(b_first - a_last), 64'(EXP_GAP));
        chk("b2b_end_valid", 64'(bus.out_valid), 64'd0);

        // Flush while byte 10 is presented and the sink is ready.
        send_block(BLK_INC, 1'b0, "fl", 10, fb, lb, cyc);
        chk("fl_pre_data", 64'(bus.out_data), 64'h0A);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("fl_blk_ready", 64'(bus.blk_ready), 64'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_out_last",  64'(bus.out_last),  64'd0);
        chk("fl_out_data",  64'(bus.out_data),  64'd0);
        chk("fl_busy",      64'(bus.busy),      64'd0);
        chk("fl_ready",     64'(bus.blk_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_quiet", 64'(bus.out_valid), 64'd0);
        end
        send_block(BLK_MIX, 1'b0, "fl_next", 32, fb, lb, cyc);
        chk("fl_next_first", 64'(fb), 64'h01);

        // Asynchronous reset with cnt == 17.
        send_block(BLK_INC, 1'b0, "rs", 17, fb, lb, cyc);
        chk("rs_pre_data", 64'(bus.out_data), 64'h11);
        rst = 1'b1;
        #1;
        chk("rs_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rs_out_data",  64'(bus.out_data),  64'd0);
        chk("rs_out_last",  64'(bus.out_last),  64'd0);
        chk("rs_busy",      64'(bus.busy),      64'd0);
        chk("rs_blk_ready", 64'(bus.blk_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rs_rel_ready", 64'(bus.blk_ready), 64'd1);
        send_block(BLK_AA, 1'b0, "rs_next", 32, fb, lb, cyc);
        chk("rs_next_first", 64'(fb), 64'hAA);

`ifdef DIGEST_SER_DOUBLE_BUF_EN
        // Block held during SEND, then discarded by flush.
        send_block(BLK_INC, 1'b0, "hd", 5, fb, lb, cyc);
        bus.out_ready = 1'b0;
        bus.blk_data  = BLK_MIX;
        bus.blk_valid = 1'b1;
        #1;
        chk("hd_offer_ready", 64'(bus.blk_ready), 64'd1);
        tick();
        bus.blk_valid = 1'b0;
        #1;
        chk("hd_held_ready", 64'(bus.blk_ready), 64'd0);
        chk("hd_held_busy",  64'(bus.busy),      64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        chk("hd_fl_busy",  64'(bus.busy),      64'd0);
        chk("hd_fl_ready", 64'(bus.blk_ready), 64'd1);
        chk("hd_fl_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hd_quiet", 64'(bus.out_valid), 64'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
